mat4add_feeder: RTL and testbench
=================================

# mat4add_feeder

Operand loader and result capture stage placed directly upstream of `mat4add`.
- Accepts a 64-bit element stream over a valid/ready handshake and packs eight elements into the 256-bit `a` and `b` operand buses.
- Pulses `start` for one cycle, then holds the operands stable until the adder raises `done`.
- Latches the adder's 256-bit `c` result and presents it with a one-cycle valid pulse.

## Interface
- `ELEM_W`, 64, width of one matrix element.
- `N_ELEM`, 4, elements per operand; operand width is `ELEM_W*N_ELEM` = 256.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a valid element.
- `in_ready`  out  1  feeder accepts an element this cycle.
- `in_data`  in  ELEM_W  element value.
- `a`  out  ELEM_W*N_ELEM  operand A, connects to `mat4add.a`.
- `b`  out  ELEM_W*N_ELEM  operand B, connects to `mat4add.b`.
- `start`  out  1  one-cycle launch pulse to `mat4add.start`.
- `done`  in  1  completion from `mat4add.done`.
- `c`  in  ELEM_W*N_ELEM  result from `mat4add.c`.
- `res`  out  ELEM_W*N_ELEM  latched result.
- `res_valid`  out  1  one-cycle pulse; `res` was updated this cycle.
- `busy`  out  1  high whenever the state is not FILL.

## Operation
- States: FILL, FIRE, WAIT. A 3-bit counter `cnt` (0..7) indexes elements.
- **FILL:**
  - `in_ready`=1.
  - A handshake (`in_valid` & `in_ready`) writes `in_data` into element slot `cnt[1:0]` and increments `cnt`.
  - `cnt[2]`=0 selects `a`, `cnt[2]`=1 selects `b`.
  - Slot k occupies bits `[64k+63:64k]`, so element 0 is the least significant.
  - A handshake at `cnt`=7 sets `cnt` to 0, moves to FIRE and registers `start`=1.
- **FIRE:** lasts exactly one cycle. `start`=1 and `in_ready`=0. Next state is WAIT, with `start` returning to 0.
- **WAIT:**
  - `in_ready`=0; `a` and `b` stay frozen.
  - When `done`=1: register `res` <= `c`, `res_valid` <= 1, state <= FILL.
  - `res_valid` drops on the following edge.
- `done` is sampled only in WAIT. In FILL and FIRE it is ignored, and `res`/`res_valid` are unchanged.
- `a` and `b` are not cleared between transactions. Each slot is overwritten as its new element arrives.
- `res` holds its value until the next capture.
- No arithmetic is performed here. Data is copied bit-exact with no width change.

## Timing
- **Reset (asynchronous, immediate):**
  - State = FILL, `cnt`=0.
  - `a`, `b`, `res` = 0; `start`, `res_valid`, `busy` = 0.
  - `in_ready`=1 as soon as `rst` deasserts.
- `in_ready` and `busy` are decoded from registered state, with no combinational path from `in_valid`.
- Throughput: one element per cycle with `in_valid` held high.
- Start latency: the 8th handshake is at edge N; `start` is high from edge N to edge N+1; WAIT is entered at N+1.
- Minimum turnaround: `done` sampled at edge M gives `res_valid` high from M to M+1 and `in_ready`=1 from M.
  - The earliest `done` is the cycle after `start`, so 8 + 1 + 1 cycles minimum per transaction.
- `in_valid` deasserted mid-fill stalls without loss; `cnt` holds.
- `in_valid` asserted in FIRE or WAIT is not accepted, and the data is ignored.
- Reset mid-transaction (any state) aborts immediately. Partial operands are cleared and no `start` or `res_valid` is emitted.
- `done` held high for multiple cycles produces only one capture. The state has already left WAIT, and FILL ignores `done`.

## Test plan
- Reset, then stream 1,2,3,4,1,2,3,4 with `in_valid` held high.
  - Required: `a` = `b` = 0x0000000000000004_0000000000000003_0000000000000002_0000000000000001.
  - Required: `start` is high for exactly 1 cycle, on the edge after the 8th handshake.
  - Required: `in_ready`=0 until `done`.
- Same stream, then model `done`=1 one cycle after `start` with `c` = {8,6,4,2}. Required: `res` = {8,6,4,2}, `res_valid` pulses once, `in_ready` returns to 1.
- Insert random `in_valid` gaps of 0–3 cycles while streaming 0xA..0x11.
  - Required: `a` = {0xD,0xC,0xB,0xA}, `b` = {0x11,0x10,0xF,0xE}.
  - Required: `start` occurs only after the 8th accepted element.
- Hold `in_valid`=1 with data 0xDEAD during WAIT, and pulse `done` during FILL. Required: no element accepted, `a`/`b`/`res` unchanged, no `res_valid`.
- Assert `rst` after 5 accepted elements. Required: `a`=`b`=0, `cnt`=0, no `start`; a fresh 8-element stream then behaves as in scenario 1.
- Run two back-to-back transactions with `done` held high for 3 cycles. Required: exactly one `res_valid` per transaction, and the second-transaction operands are correct.

Source files
------------

// File: rtl/mat4add_feeder.sv
// mat4add_feeder: packs a 64-bit element stream into the a/b operand buses of
// mat4add, fires a one-cycle start pulse, freezes the operands until done, and
// captures the c result with a one-cycle valid pulse.
// N_ELEM must be a power of two >= 2 (the element counter splits into slot/select bits).
module mat4add_feeder #(
  parameter int ELEM_W = 64,
  parameter int N_ELEM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W-1:0]          in_data,
  output logic [ELEM_W*N_ELEM-1:0]   a,
  output logic [ELEM_W*N_ELEM-1:0]   b,
  output logic                       start,
  input  logic                       done,
  input  logic [ELEM_W*N_ELEM-1:0]   c,
  output logic [ELEM_W*N_ELEM-1:0]   res,
  output logic                       res_valid,
  output logic                       busy
);

  localparam int OP_W   = ELEM_W * N_ELEM;
  localparam int SLOT_W = $clog2(N_ELEM);
  localparam int CNT_W  = SLOT_W + 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]   res_q, res_d;
  logic              start_q, start_d;
  logic              res_valid_q, res_valid_d;
  logic [SLOT_W-1:0] slot;
  logic              sel_b;

  // Next-state, operand packing and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    start_d     = 1'b0;
    res_valid_d = 1'b0;
    slot        = cnt_q[SLOT_W-1:0];
    sel_b       = cnt_q[CNT_W-1];
    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (sel_b) b_d[slot*ELEM_W +: ELEM_W] = in_data;
          else       a_d[slot*ELEM_W +: ELEM_W] = in_data;
          // Counter wraps to zero naturally on the last element.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = FIRE;
            start_d = 1'b1;
          end
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        if (done) begin
          res_d       = c;
          res_valid_d = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != FILL);
  assign a         = a_q;
  assign b         = b_q;
  assign res       = res_q;
  assign start     = start_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mat4add_feeder.sv
// Self-checking bench for mat4add_feeder: a per-cycle vector table for the basic
// transaction, then directed and randomized sequences checked against a
// last-write-per-slot model of the accepted element stream.
module tb_mat4add_feeder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [255:0] a;
  logic [255:0] b;
  logic         start;
  logic         done;
  logic [255:0] c;
  logic [255:0] res;
  logic         res_valid;
  logic         busy;

  mat4add_feeder #(.ELEM_W(64), .N_ELEM(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .a(a), .b(b), .start(start), .done(done), .c(c),
    .res(res), .res_valid(res_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int rv_cnt = 0;
  int exp_starts = 0;
  int exp_rv = 0;

  // Elements accepted since the last reset, in arrival order.
  logic [63:0] acc[$];

  typedef struct {
    logic         vld;
    logic [63:0]  data;
    logic         dn;
    logic [255:0] cv;
    logic         e_rdy;
    logic         e_start;
    logic         e_rv;
    logic         e_busy;
  } row_t;

  row_t tbl[12];

  localparam logic [255:0] A1 = {64'd4, 64'd3, 64'd2, 64'd1};
  localparam logic [255:0] C1 = {64'd8, 64'd6, 64'd4, 64'd2};

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (res_valid === 1'b1) rv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic row_t mk(input logic v, input logic [63:0] d, input logic dn,
                              input logic [255:0] cv, input logic r, input logic s,
                              input logic rv, input logic bz);
    row_t x;
    x.vld = v; x.data = d; x.dn = dn; x.cv = cv;
    x.e_rdy = r; x.e_start = s; x.e_rv = rv; x.e_busy = bz;
    return x;
  endfunction

  // Operand model: slot k of a (sel=0) or b (sel=1) holds the latest element
  // whose arrival index i satisfies i%4==k and (i/4)%2==sel.
  function automatic logic [255:0] model_op(input int sel);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < acc.size(); i++)
      if (((i / 4) % 2) == sel) r[(i % 4) * 64 +: 64] = acc[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 256'(act), 256'(exp));
  endtask

  // Sends the queued elements with random idle gaps; expects start only after the 8th.
  task automatic stream(input logic [63:0] d[$], input int unsigned maxgap);
    int unsigned t;
    foreach (d[i]) begin
      in_valid = 1'b0;
      repeat ((maxgap != 0) ? $urandom_range(maxgap, 0) : 0) tick();
      in_valid = 1'b1;
      in_data  = d[i];
      t = 0;
      while (!in_ready && t < 16) begin
        tick();
        t++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: in_ready got 0, expected 1");
        in_valid = 1'b0;
        return;
      end
      tick();
      acc.push_back(d[i]);
      if (i == 7) exp_starts++;
      chk1($sformatf("start_at_elem%0d", i), start, (i == 7));
    end
    in_valid = 1'b0;
  endtask

  // Called in FIRE: enters WAIT, waits `delay` cycles, then holds done for `hold` cycles.
  task automatic finish_txn(input logic [255:0] cv, input int unsigned delay, input int unsigned hold);
    tick();
    chk1("fire_one_cycle", start, 1'b0);
    chk1("wait_busy", busy, 1'b1);
    repeat (delay) begin
      tick();
      chk1("wait_in_ready", in_ready, 1'b0);
    end
    done = 1'b1;
    c    = cv;
    tick();
    exp_rv++;
    chk1("capture_res_valid", res_valid, 1'b1);
    check("capture_res", res, cv);
    chk1("capture_in_ready", in_ready, 1'b1);
    for (int unsigned h = 1; h < hold; h++) begin
      tick();
      chk1("done_held_no_recapture", res_valid, 1'b0);
      check("done_held_res", res, cv);
    end
    done = 1'b0;
    c    = '0;
  endtask

  initial begin
    logic [63:0]  q[$];
    logic [255:0] cr;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; done = 1'b0; c = '0;

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1'b1, 64'((i % 4) + 1), 1'b0, '0, (i < 7), (i == 7), 1'b0, (i == 7));
    tbl[8]  = mk(1'b1, 64'hDEAD, 1'b1, '1, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 64'h0, 1'b1, C1, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 64'h0, 1'b1, C1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 64'h0, 1'b1, '1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state.
    tick(); tick();
    check("reset_a", a, '0);
    check("reset_b", b, '0);
    check("reset_res", res, '0);
    chk1("reset_start", start, 1'b0);
    chk1("reset_res_valid", res_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);

    // Per-cycle vector table: fill 1,2,3,4,1,2,3,4, done ignored in FIRE, capture, done ignored in FILL.
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      done     = tbl[i].dn;
      c        = tbl[i].cv;
      tick();
      chk1($sformatf("row%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk1($sformatf("row%0d_start", i), start, tbl[i].e_start);
      chk1($sformatf("row%0d_res_valid", i), res_valid, tbl[i].e_rv);
      chk1($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
    end
    in_valid = 1'b0; done = 1'b0; c = '0;
    exp_starts++;
    exp_rv++;
    check("table_a", a, A1);
    check("table_b", b, A1);
    check("table_res", res, C1);

    // Gapped stream 0xA..0x11, then WAIT ignores input, FILL ignores done.
    rst = 1'b1; acc.delete(); tick(); rst = 1'b0;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(64'(10 + i));
    stream(q, 3);
    check("gap_a", a, {64'hD, 64'hC, 64'hB, 64'hA});
    check("gap_b", b, {64'h11, 64'h10, 64'hF, 64'hE});
    in_valid = 1'b1; in_data = 64'hDEAD;
    tick();
    chk1("fire_to_wait_start", start, 1'b0);
    repeat (4) begin
      tick();
      chk1("wait_blocks_in_ready", in_ready, 1'b0);
      chk1("wait_no_res_valid", res_valid, 1'b0);
    end
    in_valid = 1'b0;
    check("wait_a_frozen", a, model_op(0));
    check("wait_b_frozen", b, model_op(1));
    cr = rand256();
    done = 1'b1; c = cr;
    tick();
    exp_rv++;
    chk1("gap_res_valid", res_valid, 1'b1);
    check("gap_res", res, cr);
    done = 1'b0; c = '0;
    tick();
    chk1("res_valid_drops", res_valid, 1'b0);
    done = 1'b1; c = ~cr;
    tick();
    chk1("fill_done_no_res_valid", res_valid, 1'b0);
    check("fill_done_res_kept", res, cr);
    check("fill_done_a_kept", a, model_op(0));
    done = 1'b0; c = '0;

    // Reset after 5 accepted elements, then a fresh 1..4,1..4 stream.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back({$urandom, $urandom});
    stream(q, 1);
    rst = 1'b1;
    #1;
    check("midrst_a", a, '0);
    check("midrst_b", b, '0);
    check("midrst_res", res, '0);
    chk1("midrst_start", start, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_res_valid", res_valid, 1'b0);
    acc.delete();
    tick();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(64'((i % 4) + 1));
    stream(q, 0);
    check("post_rst_a", a, A1);
    check("post_rst_b", b, A1);
    finish_txn(C1, 0, 3);

    // Back-to-back transactions with done held for three cycles, then random ones.
    for (int t = 0; t < 6; t++) begin
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back({$urandom, $urandom});
      stream(q, (t < 2) ? 0 : 2);
      check($sformatf("txn%0d_a", t), a, model_op(0));
      check($sformatf("txn%0d_b", t), b, model_op(1));
      finish_txn(rand256(), (t < 2) ? 0 : $urandom_range(3, 0), (t < 2) ? 3 : $urandom_range(2, 1));
    end

    tick();
    check("start_pulse_count", 256'(start_cnt), 256'(exp_starts));
    check("res_valid_pulse_count", 256'(rv_cnt), 256'(exp_rv));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
